// File: rtl/bypass_scoreboard_if.sv
// Pipeline-side bundle for bypass_scoreboard: hazard fields in, forward selects and stalls out.
// Optional stall counters appear only when BYPASS_STALL_CNT_EN is defined.
interface bypass_scoreboard_if #(
  parameter int NUM_STAGES = 2,
  parameter int REG_W      = 5,
  parameter int SEL_W      = 2
);
  logic [REG_W-1:0]            ex_rs1;
  logic [REG_W-1:0]            ex_rs2;
  logic                        ex_rs1_used;
  logic                        ex_rs2_used;
  logic [REG_W-1:0]            ex_rd;
  logic                        ex_is_md;
  logic                        ex_valid;
  logic [NUM_STAGES*REG_W-1:0] stg_rd;
  logic [NUM_STAGES-1:0]       stg_wen;
  logic [NUM_STAGES-1:0]       stg_exc;
  logic                        mem_is_load;
  logic [REG_W-1:0]            mem_store_rd;
  logic                        mem_is_store;
  logic                        md_done;
  logic [SEL_W-1:0]            fwd_a;
  logic [SEL_W-1:0]            fwd_b;
  logic                        dmem_fwd;
  logic                        stall;
  logic                        md_busy;
  logic [REG_W-1:0]            md_rd;
`ifdef BYPASS_STALL_CNT_EN
  logic [31:0]                 stall_cnt;
  logic [31:0]                 md_stall_cnt;
`endif

  modport master (
    output ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_rd, ex_is_md, ex_valid,
    output stg_rd, stg_wen, stg_exc, mem_is_load, mem_store_rd, mem_is_store, md_done,
    input  fwd_a, fwd_b, dmem_fwd, stall, md_busy, md_rd
`ifdef BYPASS_STALL_CNT_EN
    , input stall_cnt, md_stall_cnt
`endif
  );

  modport slave (
    input  ex_rs1, ex_rs2, ex_rs1_used, ex_rs2_used, ex_rd, ex_is_md, ex_valid,
    input  stg_rd, stg_wen, stg_exc, mem_is_load, mem_store_rd, mem_is_store, md_done,
    output fwd_a, fwd_b, dmem_fwd, stall, md_busy, md_rd
`ifdef BYPASS_STALL_CNT_EN
    , output stall_cnt, md_stall_cnt
`endif
  );
endinterface

// File: rtl/bypass_scoreboard.sv
// Operand/store-data forwarding, load-use and mult/div stalls, and a one-entry mult/div scoreboard.
// Define BYPASS_STALL_CNT_EN to add saturating stall_cnt / md_stall_cnt counters.
module bypass_scoreboard #(
  parameter int NUM_STAGES = 2,
  parameter int REG_W      = 5,
  parameter int EXC_REG    = 30,
  parameter int SEL_W      = 2
) (
  input logic                clock,
  input logic                reset,
  bypass_scoreboard_if.slave bus
);
  logic [REG_W-1:0]      eff_rd_s [NUM_STAGES];
  logic [NUM_STAGES-1:0] cand_s;
  logic [NUM_STAGES-1:0] match_a_s;
  logic [NUM_STAGES-1:0] match_b_s;
  logic [SEL_W-1:0]      fwd_a_s;
  logic [SEL_W-1:0]      fwd_b_s;
  logic                  dmem_fwd_s;
  logic                  load_use_s;
  logic                  md_raw_s;
  logic                  md_waw_s;
  logic                  md_stall_s;
  logic                  stall_s;
  logic                  capture_s;
  logic                  md_busy_r;
  logic [REG_W-1:0]      md_rd_r;

  // Effective destinations and per-stage source matches; exceptions redirect to EXC_REG.
  always_comb begin
    cand_s    = '0;
    match_a_s = '0;
    match_b_s = '0;
    for (int k = 0; k < NUM_STAGES; k++) begin
      eff_rd_s[k]  = bus.stg_exc[k] ? REG_W'(EXC_REG) : bus.stg_rd[k*REG_W +: REG_W];
      cand_s[k]    = (bus.stg_wen[k] | bus.stg_exc[k]) & (eff_rd_s[k] != '0);
      match_a_s[k] = cand_s[k] & bus.ex_rs1_used & (bus.ex_rs1 != '0) & (eff_rd_s[k] == bus.ex_rs1);
      match_b_s[k] = cand_s[k] & bus.ex_rs2_used & (bus.ex_rs2 != '0) & (eff_rd_s[k] == bus.ex_rs2);
    end
  end

  // Walk from the farthest stage inward so the nearest matching stage overrides.
  always_comb begin
    fwd_a_s = '0;
    fwd_b_s = '0;
    for (int k = NUM_STAGES - 1; k >= 0; k--) begin
      fwd_a_s = match_a_s[k] ? SEL_W'(k + 1) : fwd_a_s;
      fwd_b_s = match_b_s[k] ? SEL_W'(k + 1) : fwd_b_s;
    end
  end

  // Store-data bypass from writeback and the combined stall.
  always_comb begin
    dmem_fwd_s = bus.mem_is_store & cand_s[NUM_STAGES-1] & (bus.mem_store_rd != '0)
               & (eff_rd_s[NUM_STAGES-1] == bus.mem_store_rd);
    load_use_s = bus.mem_is_load & bus.stg_wen[0] & (bus.stg_rd[REG_W-1:0] != '0)
               & ((bus.ex_rs1_used & (bus.ex_rs1 == bus.stg_rd[REG_W-1:0]))
                | (bus.ex_rs2_used & (bus.ex_rs2 == bus.stg_rd[REG_W-1:0])));
    // A pending r0 mult/div never creates a true dependency.
    md_raw_s   = (md_rd_r != '0)
               & ((bus.ex_rs1_used & (bus.ex_rs1 == md_rd_r))
                | (bus.ex_rs2_used & (bus.ex_rs2 == md_rd_r)));
    md_waw_s   = (bus.ex_rd != '0) & (bus.ex_rd == md_rd_r);
    md_stall_s = md_busy_r & bus.ex_valid & (md_raw_s | md_waw_s | bus.ex_is_md);
    stall_s    = load_use_s | md_stall_s;
    capture_s  = bus.ex_valid & bus.ex_is_md & ~stall_s;
  end

  // Scoreboard entry: a new capture takes priority over a completing md_done.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      md_busy_r <= 1'b0;
      md_rd_r   <= '0;
    end else if (capture_s) begin
      md_busy_r <= 1'b1;
      md_rd_r   <= bus.ex_rd;
    end else if (bus.md_done) begin
      md_busy_r <= 1'b0;
    end
  end

  assign bus.fwd_a    = fwd_a_s;
  assign bus.fwd_b    = fwd_b_s;
  assign bus.dmem_fwd = dmem_fwd_s;
  assign bus.stall    = stall_s;
  assign bus.md_busy  = md_busy_r;
  assign bus.md_rd    = md_rd_r;

`ifdef BYPASS_STALL_CNT_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] md_stall_cnt_r;

  // Saturating stall-cycle counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cnt_r    <= 32'd0;
      md_stall_cnt_r <= 32'd0;
    end else begin
      if (stall_s && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'd1;
      end
      if (md_stall_s && (md_stall_cnt_r != 32'hFFFF_FFFF)) begin
        md_stall_cnt_r <= md_stall_cnt_r + 32'd1;
      end
    end
  end

  assign bus.stall_cnt    = stall_cnt_r;
  assign bus.md_stall_cnt = md_stall_cnt_r;
`endif
endmodule

// File: tb/tb_bypass_scoreboard.sv
// Directed-vector scoreboard bench for bypass_scoreboard: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_bypass_scoreboard;
  logic clock;
  logic reset;

  bypass_scoreboard_if #(.NUM_STAGES(2), .REG_W(5), .SEL_W(2)) bus ();

  bypass_scoreboard #(.NUM_STAGES(2), .REG_W(5), .EXC_REG(30), .SEL_W(2)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        dm;
    logic        st;
    logic        mb;
    logic [4:0]  mr;
    logic        chk_cnt;
    logic [31:0] sc;
    logic [31:0] msc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic clear();
    bus.ex_rs1 = 5'd0; bus.ex_rs2 = 5'd0; bus.ex_rs1_used = 1'b0; bus.ex_rs2_used = 1'b0;
    bus.ex_rd = 5'd0; bus.ex_is_md = 1'b0; bus.ex_valid = 1'b0;
    bus.stg_rd = 10'd0; bus.stg_wen = 2'b00; bus.stg_exc = 2'b00;
    bus.mem_is_load = 1'b0; bus.mem_store_rd = 5'd0; bus.mem_is_store = 1'b0; bus.md_done = 1'b0;
  endtask

  task automatic push(input string nm, input logic [1:0] fa, input logic [1:0] fb, input logic dm,
                      input logic st, input logic mb, input logic [4:0] mr);
    exp_t e;
    e = '{fa: fa, fb: fb, dm: dm, st: st, mb: mb, mr: mr, chk_cnt: 1'b0, sc: 32'd0, msc: 32'd0};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic push_cnt(input string nm, input logic st, input logic [31:0] sc, input logic [31:0] msc);
    exp_t e;
    e = '{fa: 2'd0, fb: 2'd0, dm: 1'b0, st: st, mb: 1'b0, mr: 5'd0, chk_cnt: 1'b1, sc: sc, msc: msc};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Monitor: one expectation per cycle, checked mid-cycle.
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string nm;
      logic  bad;
      e   = exp_q.pop_front();
      nm  = name_q.pop_front();
      bad = (bus.fwd_a !== e.fa) || (bus.fwd_b !== e.fb) || (bus.dmem_fwd !== e.dm) ||
            (bus.stall !== e.st) || (bus.md_busy !== e.mb) || (bus.md_rd !== e.mr);
`ifdef BYPASS_STALL_CNT_EN
      if (e.chk_cnt && ((bus.stall_cnt !== e.sc) || (bus.md_stall_cnt !== e.msc))) begin
        bad = 1'b1;
        $display("FAIL %s counters: got stall_cnt=%0d md_stall_cnt=%0d want %0d %0d",
                 nm, bus.stall_cnt, bus.md_stall_cnt, e.sc, e.msc);
      end
`endif
      n_cmp = n_cmp + 1;
      if (bad) begin
        n_bad = n_bad + 1;
        $display("FAIL %s: got fa=%0d fb=%0d dm=%0b st=%0b busy=%0b rd=%0d want fa=%0d fb=%0d dm=%0b st=%0b busy=%0b rd=%0d",
                 nm, bus.fwd_a, bus.fwd_b, bus.dmem_fwd, bus.stall, bus.md_busy, bus.md_rd,
                 e.fa, e.fb, e.dm, e.st, e.mb, e.mr);
      end
    end
  end

  initial begin
    reset = 1'b1;
    clear();
    #1;
    push("rst", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0);
    step(); step();
    reset = 1'b0;

    // Forwarding priority, exceptions, r0 and unused sources.
    clear(); bus.ex_valid = 1'b1; bus.ex_rs1 = 5'd5; bus.ex_rs1_used = 1'b1;
    bus.stg_rd = {5'd5, 5'd5}; bus.stg_wen = 2'b11;
    push("near", 2'd1, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();
    bus.stg_wen = 2'b10;
    push("far", 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();
    bus.stg_wen = 2'b11; bus.ex_rs2 = 5'd5; bus.ex_rs2_used = 1'b1;
    push("both", 2'd1, 2'd1, 1'b0, 1'b0, 1'b0, 5'd0); step();
    clear(); bus.ex_rs2 = 5'd30; bus.ex_rs2_used = 1'b1; bus.stg_exc = 2'b10; bus.stg_rd = {5'd7, 5'd0};
    push("exc", 2'd0, 2'd2, 1'b0, 1'b0, 1'b0, 5'd0); step();
    bus.ex_rs2 = 5'd0; bus.stg_wen = 2'b01;
    push("r0", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();
    bus.ex_rs2 = 5'd30; bus.ex_rs2_used = 1'b0;
    push("unused", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();

    // Store-data bypass from writeback.
    clear(); bus.mem_is_store = 1'b1; bus.mem_store_rd = 5'd12; bus.stg_rd = {5'd12, 5'd0}; bus.stg_wen = 2'b10;
    push("dmem", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0); step();
    bus.mem_store_rd = 5'd0; bus.stg_rd = 10'd0;
    push("dmem_r0", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();
    bus.mem_store_rd = 5'd30; bus.stg_rd = {5'd4, 5'd0}; bus.stg_wen = 2'b00; bus.stg_exc = 2'b10;
    push("dmem_exc", 2'd0, 2'd0, 1'b1, 1'b0, 1'b0, 5'd0); step();

    // Load-use: stall while the load is in memory, forward once it reaches writeback.
    clear(); bus.ex_valid = 1'b1; bus.ex_rs1 = 5'd3; bus.ex_rs1_used = 1'b1;
    bus.mem_is_load = 1'b1; bus.stg_rd = {5'd0, 5'd3}; bus.stg_wen = 2'b01;
    push("ldu", 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 5'd0); step();
    bus.mem_is_load = 1'b0; bus.stg_rd = {5'd3, 5'd0}; bus.stg_wen = 2'b10;
    push("ldu_adv", 2'd2, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();
    bus.mem_is_load = 1'b1; bus.stg_rd = {5'd0, 5'd3}; bus.stg_wen = 2'b01; bus.ex_rs1_used = 1'b0;
    push("ldu_unused", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();

    // Mult/div RAW and release.
    clear(); bus.ex_valid = 1'b1; bus.ex_is_md = 1'b1; bus.ex_rd = 5'd9;
    push("md_issue", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();
    clear(); bus.ex_valid = 1'b1; bus.ex_rs2 = 5'd9; bus.ex_rs2_used = 1'b1; bus.ex_rd = 5'd1;
    push("md_raw1", 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd9); step();
    push("md_raw2", 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd9); step();
    bus.md_done = 1'b1;
    push("md_done_cyc", 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd9); step();
    bus.md_done = 1'b0;
    push("md_rel", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd9); step();

    // Structural hazard, then md_done while idle colliding with a new capture.
    clear(); bus.ex_valid = 1'b1; bus.ex_is_md = 1'b1; bus.ex_rd = 5'd2;
    push("md_cap2", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd9); step();
    bus.ex_rd = 5'd4;
    push("md_struct", 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd2); step();
    bus.md_done = 1'b1;
    push("md_done2", 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd2); step();
    push("md_coll_pre", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd2); step();
    clear();
    push("md_coll", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd4); step();
    bus.ex_valid = 1'b1; bus.ex_rd = 5'd4;
    push("md_waw", 2'd0, 2'd0, 1'b0, 1'b1, 1'b1, 5'd4); step();
    bus.ex_valid = 1'b0;
    push("md_bubble", 2'd0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd4); step();

    // Asynchronous reset between edges drops the pending mult/div.
    reset = 1'b1; clear();
    push_cnt("arst", 1'b0, 32'd0, 32'd0); step();
    reset = 1'b0;
    bus.ex_rs1 = 5'd3; bus.ex_rs1_used = 1'b1; bus.mem_is_load = 1'b1;
    bus.stg_rd = {5'd0, 5'd3}; bus.stg_wen = 2'b01;
    for (int i = 0; i < 3; i++) begin
      push("cnt_ldu", 2'd1, 2'd0, 1'b0, 1'b1, 1'b0, 5'd0); step();
    end
    clear();
    push_cnt("cnt3", 1'b0, 32'd3, 32'd0); step();
    bus.md_done = 1'b1;
    push("done_idle", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();
    clear();
    push("after_done", 2'd0, 2'd0, 1'b0, 1'b0, 1'b0, 5'd0); step();

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clock);
    if (exp_q.size() > 0) begin
      n_bad = n_bad + 1;
      $display("FAIL drain: got %0d pending expectations want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/bypass_scoreboard.md
Name: bypass_scoreboard

Overview:
- Parametrised successor to the single-config hazard bypass unit.
- Selects operand forwarding for execute-stage sources A and B across NUM_STAGES downstream pipeline stages, nearest stage first.
- Generates the store-data bypass for the memory stage.
- Adds a sequential scoreboard for one outstanding multi-cycle mult/div result, plus load-use and mult/div stall generation. Sits beside the pipeline latches; all decode is done upstream and arrives as fields.

Parameters:
- NUM_STAGES, 2, number of forwarding source stages after execute; index 0 = memory, NUM_STAGES-1 = writeback.
- REG_W, 5, register address width.
- EXC_REG, 30, register substituted as destination when a stage carries an exception.
- SEL_W, 2, width of forward selects; must satisfy 2^SEL_W >= NUM_STAGES+1.

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  asynchronous active-high reset.
- ex_rs1  in  REG_W  execute source A register.
- ex_rs2  in  REG_W  execute source B register.
- ex_rs1_used, ex_rs2_used  in  1 each  source actually read.
- ex_rd  in  REG_W  execute destination.
- ex_is_md  in  1  execute holds a mult/div.
- ex_valid  in  1  execute holds a live (non-bubble, non-flushed) instruction.
- stg_rd  in  NUM_STAGES*REG_W  flattened destination per stage; stage k at bits [k*REG_W +: REG_W].
- stg_wen  in  NUM_STAGES  stage writes a register.
- stg_exc  in  NUM_STAGES  stage carries an exception.
- mem_is_load  in  1  stage 0 is a load.
- mem_store_rd  in  REG_W  data register of a store in stage 0.
- mem_is_store  in  1  stage 0 is a store.
- md_done  in  1  mult/div unit result-ready pulse.
- fwd_a, fwd_b  out  SEL_W  0 = register file; k = stage k-1.
- dmem_fwd  out  1  forward writeback result into store data.
- stall  out  1  hold fetch/decode/execute; inject bubble into memory.
- md_busy  out  1  scoreboard holds a pending mult/div.
- md_rd  out  REG_W  pending mult/div destination.

Behaviour:
- Effective destination: eff_rd[k] = stg_exc[k] ? EXC_REG : stg_rd[k].
  - Stage k is a forward candidate iff (stg_wen[k] | stg_exc[k]) and eff_rd[k] != 0.
- fwd_a selection:
  - Lowest k whose candidate eff_rd[k] == ex_rs1, with ex_rs1_used and ex_rs1 != 0; output k+1.
  - Otherwise 0.
  - fwd_b is identical using ex_rs2.
  - A closer stage always wins over a farther one.
- dmem_fwd = mem_is_store & stage NUM_STAGES-1 is a candidate & eff_rd[NUM_STAGES-1] == mem_store_rd & mem_store_rd != 0.
- Load-use stall: mem_is_load & stg_wen[0] & stg_rd[0] != 0 & a used ex source equals stg_rd[0]. Asserts for one cycle; the next cycle the load sits in stage 1 and forwards normally.
- Mult/div stall: md_busy & ex_valid & any of the following:
  - a used source == md_rd (RAW);
  - ex_rd == md_rd with ex_rd != 0 (WAW);
  - ex_is_md (structural).
- stall = load_use | md_stall. Both are combinational from inputs and current state.
- Scoreboard registers, md_busy and md_rd, updated on rising clock:
  - Capture: ex_valid & ex_is_md & ~stall sets md_busy=1 and md_rd=ex_rd.
  - Clear: md_done clears md_busy; md_rd is held.
  - Simultaneous md_done and capture: capture wins, so md_busy stays 1 with the new md_rd.
  - md_done while idle: ignored.
  - A mult/div with ex_rd == 0 is still captured and completes normally, but never causes a RAW stall.
- The md result is written in the md_done cycle through the write-before-read register file, so the stall drops the cycle after md_done.
- Reset, asynchronous:
  - md_busy=0, md_rd=0, counters cleared.
  - fwd_a, fwd_b, dmem_fwd and stall are combinational and follow inputs immediately. With md_busy=0 only the load-use term can assert stall.
- Reset mid-operation: a pending mult/div is dropped; a later md_done is ignored.

Optional Feature:
- Macro BYPASS_STALL_CNT_EN.
- When defined, adds the following outputs:
  - stall_cnt, out, 32: saturating count of cycles with stall=1.
  - md_stall_cnt, out, 32: saturating count of cycles with md_stall=1.
- Both counters clear on reset and hold at 32'hFFFFFFFF.
- When undefined, these ports and registers do not exist and the remaining behaviour is identical.

Test Plan:
- Nearest-stage priority:
  - Stimulus: ex_rs1=5; stage0 rd=5 wen; stage1 rd=5 wen.
  - Expect: fwd_a=1. Drop stage0 wen -> fwd_a=2.
- Exception override and r0:
  - Stimulus: stage1 stg_exc=1, stg_rd=7, ex_rs2=30.
  - Expect: fwd_b=2. With ex_rs2=0 and a matching candidate -> fwd_b=0.
- Load-use:
  - Stimulus: stage0 load rd=3, ex_rs1=3.
  - Expect: stall=1 that cycle. After advancing (load in stage1), stall=0 and fwd_a=2.
- Mult/div RAW and release:
  - Stimulus: capture md rd=9.
  - Expect: md_busy=1, md_rd=9. Next instruction with rs2=9 -> stall=1 each cycle. md_done pulse -> md_busy=0 and stall=0 the following cycle.
- Done/capture collision and structural hazard:
  - Stimulus 1: md_busy, ex_is_md.
  - Expect: stall=1.
  - Stimulus 2: md_done in the same cycle the stall releases and a new md (rd=4) captures.
  - Expect: md_busy=1, md_rd=4.
- Async reset mid-operation:
  - Stimulus: assert reset between clock edges while md_busy=1.
  - Expect: md_busy=0 immediately. With BYPASS_STALL_CNT_EN, stall_cnt=0.
  - Then: 3 stall cycles -> stall_cnt=3.
